// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-driven single-port RAM behind an SPI slave
// One command executes per rx_valid assertion; reads hold dout/tx_valid until rx_valid drops.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    RD_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  state_t                 state_q;
  state_t                 state_d;
  logic [7:0]             mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0]   wr_addr;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic                   wr_addr_vld;
  logic                   rd_addr_vld;
  logic                   exec;
  logic [1:0]             op;

  assign op   = din[9:8];
  assign exec = (state_q == IDLE) && rx_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (op == OP_RD_DATA && rd_addr_vld) state_d = RD_HOLD;
          else                                 state_d = WAIT_LOW;
        end
      end
      WAIT_LOW, RD_HOLD: begin
        if (!rx_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dout        <= 8'h00;
      tx_valid    <= 1'b0;
      seq_err     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_addr_vld <= 1'b0;
      rd_addr_vld <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_err <= 1'b0;
      if (exec) begin
        case (op)
          OP_WR_ADDR: begin
            wr_addr     <= ADDR_SIZE'(din[7:0]);
            wr_addr_vld <= 1'b1;
          end
          OP_WR_DATA: begin
            if (wr_addr_vld) wr_addr <= wr_addr + ADDR_SIZE'(1);
            else             seq_err <= 1'b1;
          end
          OP_RD_ADDR: begin
            rd_addr     <= ADDR_SIZE'(din[7:0]);
            rd_addr_vld <= 1'b1;
          end
          default: begin
            // Each read consumes its address; the next read needs a fresh 10 command.
            if (rd_addr_vld) begin
              dout        <= mem[rd_addr];
              tx_valid    <= 1'b1;
              rd_addr     <= rd_addr + ADDR_SIZE'(1);
              rd_addr_vld <= 1'b0;
            end else begin
              seq_err <= 1'b1;
            end
          end
        endcase
      end
      if (state_q == RD_HOLD && !rx_valid) tx_valid <= 1'b0;
    end
  end

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (exec && op == OP_WR_DATA && wr_addr_vld) mem[wr_addr] <= din[7:0];
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - directed self-checking bench for spi_ram_ctrl
module tb_spi_ram_ctrl;
  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       seq_err;

  int checks;
  int passed;

  logic       e_seq, e_tx, p_seq, h_tx, a_tx;
  logic [7:0] e_dout, h_dout, a_dout;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds rx_valid for n cycles and snapshots outputs at key points.
  task automatic cmd(input logic [9:0] w, input int n);
    @(negedge clk);
    din = w;
    rx_valid = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) begin e_seq = seq_err; e_tx = tx_valid; e_dout = dout; end
      if (i == 2) p_seq = seq_err;
      if (i == n) begin h_tx = tx_valid; h_dout = dout; end
    end
    rx_valid = 1'b0;
    @(negedge clk);
    a_tx = tx_valid;
    a_dout = dout;
  endtask

  task automatic rd(input logic [7:0] a);
    cmd({2'b10, a}, 2);
    cmd(10'h300, 2);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx got %b want 0", tx_valid); else passed++;
    checks++; if (seq_err !== 1'b0) $display("FAIL reset_seq got %b want 0", seq_err); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write;
    cmd(10'h000, 2);
    cmd(10'h15A, 2);
    cmd(10'h012, 3);
    checks++; if (e_seq !== 1'b0) $display("FAIL wr_addr_seq got %b want 0", e_seq); else passed++;
    cmd(10'h1A5, 3);
    checks++; if (e_seq !== 1'b0) $display("FAIL wr_data0_seq got %b want 0", e_seq); else passed++;
    cmd(10'h1C3, 3);
    checks++; if (e_seq !== 1'b0) $display("FAIL wr_data1_seq got %b want 0", e_seq); else passed++;
  endtask

  task automatic test_read;
    cmd(10'h212, 3);
    checks++; if (e_seq !== 1'b0) $display("FAIL rd_addr_seq got %b want 0", e_seq); else passed++;
    cmd(10'h300, 4);
    checks++; if (e_tx !== 1'b1) $display("FAIL rd_tx got %b want 1", e_tx); else passed++;
    checks++; if (e_dout !== 8'hA5) $display("FAIL rd_dout got %h want a5", e_dout); else passed++;
    checks++; if (h_tx !== 1'b1) $display("FAIL rd_hold_tx got %b want 1", h_tx); else passed++;
    checks++; if (h_dout !== 8'hA5) $display("FAIL rd_hold_dout got %h want a5", h_dout); else passed++;
    checks++; if (a_tx !== 1'b0) $display("FAIL rd_after_tx got %b want 0", a_tx); else passed++;
    checks++; if (a_dout !== 8'hA5) $display("FAIL rd_after_dout got %h want a5", a_dout); else passed++;
    rd(8'h13);
    checks++; if (e_dout !== 8'hC3) $display("FAIL rd_burst_word got %h want c3", e_dout); else passed++;
  endtask

  task automatic test_seq_err;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cmd(10'h300, 3);
    checks++; if (e_seq !== 1'b1) $display("FAIL seq_rd got %b want 1", e_seq); else passed++;
    checks++; if (e_tx !== 1'b0) $display("FAIL seq_rd_tx got %b want 0", e_tx); else passed++;
    checks++; if (p_seq !== 1'b0) $display("FAIL seq_rd_pulse got %b want 0", p_seq); else passed++;
    cmd(10'h177, 3);
    checks++; if (e_seq !== 1'b1) $display("FAIL seq_wr got %b want 1", e_seq); else passed++;
    checks++; if (p_seq !== 1'b0) $display("FAIL seq_wr_pulse got %b want 0", p_seq); else passed++;
    rd(8'h00);
    checks++; if (e_dout !== 8'h5A) $display("FAIL seq_nowrite got %h want 5a", e_dout); else passed++;
    rd(8'h12);
    checks++; if (e_dout !== 8'hA5) $display("FAIL retain_12 got %h want a5", e_dout); else passed++;
  endtask

  task automatic test_wrap;
    cmd(10'h0FF, 2);
    cmd(10'h111, 2);
    cmd(10'h122, 2);
    rd(8'hFF);
    checks++; if (e_dout !== 8'h11) $display("FAIL wrap_ff got %h want 11", e_dout); else passed++;
    checks++; if (dut.rd_addr !== 8'h00) $display("FAIL wrap_rd_addr got %h want 00", dut.rd_addr); else passed++;
    rd(8'h00);
    checks++; if (e_dout !== 8'h22) $display("FAIL wrap_00 got %h want 22", e_dout); else passed++;
  endtask

  task automatic test_hold;
    cmd(10'h042, 2);
    cmd(10'h199, 2);
    cmd(10'h040, 2);
    @(negedge clk);
    din = 10'h1AA;
    rx_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 4) din = 10'h1BB;
    end
    rx_valid = 1'b0;
    @(negedge clk);
    cmd(10'h1CC, 2);
    rd(8'h40);
    checks++; if (e_dout !== 8'hAA) $display("FAIL hold_40 got %h want aa", e_dout); else passed++;
    rd(8'h41);
    checks++; if (e_dout !== 8'hCC) $display("FAIL hold_41 got %h want cc", e_dout); else passed++;
    rd(8'h42);
    checks++; if (e_dout !== 8'h99) $display("FAIL hold_42 got %h want 99", e_dout); else passed++;
  endtask

  task automatic test_raw;
    cmd(10'h210, 2);
    cmd(10'h010, 2);
    cmd(10'h1E7, 2);
    cmd(10'h300, 2);
    checks++; if (e_dout !== 8'hE7) $display("FAIL raw got %h want e7", e_dout); else passed++;
  endtask

  task automatic test_rst_mid_read;
    cmd(10'h212, 2);
    @(negedge clk);
    din = 10'h300;
    rx_valid = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1) $display("FAIL mid_tx_pre got %b want 1", tx_valid); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) $display("FAIL mid_tx_rst got %b want 0", tx_valid); else passed++;
    checks++; if (dout !== 8'h00) $display("FAIL mid_dout_rst got %h want 00", dout); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (seq_err !== 1'b1) $display("FAIL mid_seq_after got %b want 1", seq_err); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL mid_tx_after got %b want 0", tx_valid); else passed++;
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    din = 10'h000;
    rx_valid = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_seq_err;
    test_wrap;
    test_hold;
    test_raw;
    test_rst_mid_read;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
